// File: rtl/mux64_arbiter.sv
// mux64_arbiter
//   Two-requester round-robin arbiter with minimum dwell for the 64-bit 2:1
//   datapath mux. Drives the mux select and registers the selected data with a
//   valid qualifier.
//
// State table:
//   ST_IDLE  | no owner; o holds, o_valid drops
//   ST_OWN_A | source A owns the mux (sel = 0)
//   ST_OWN_B | source B owns the mux (sel = 1)
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   req_a, req_b     level requests from sources A and B
//   data_a, data_b   source data (W bits)
//   gnt_a, gnt_b     current owner (registered)
//   sel              mux select, 0 = data_a, 1 = data_b (registered)
//   o, o_valid       registered mux output and its qualifier

module mux64_arbiter #(
  parameter int W     = 64,
  parameter int DWELL = 4,
  parameter int CW    = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_a,
  input  logic         req_b,
  input  logic [W-1:0] data_a,
  input  logic [W-1:0] data_b,
  output logic         gnt_a,
  output logic         gnt_b,
  output logic         sel,
  output logic [W-1:0] o,
  output logic         o_valid
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_MAX = CW'(DWELL - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_b_q, last_b_d;
  logic          sel_q, sel_d;
  logic [W-1:0]  o_q;
  logic          o_valid_q;
  logic          dwell_done;

  assign dwell_done = (cnt_q == CNT_MAX);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        // On a tie the source that was not served last wins.
        if (req_a && req_b)  state_d = last_b_q ? ST_OWN_A : ST_OWN_B;
        else if (req_a)      state_d = ST_OWN_A;
        else if (req_b)      state_d = ST_OWN_B;
      end
      ST_OWN_A: begin
        if (!req_a)                  state_d = req_b ? ST_OWN_B : ST_IDLE;
        else if (req_b && dwell_done) state_d = ST_OWN_B;
      end
      ST_OWN_B: begin
        if (!req_b)                  state_d = req_a ? ST_OWN_A : ST_IDLE;
        else if (req_a && dwell_done) state_d = ST_OWN_A;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    last_b_d = last_b_q;
    sel_d    = sel_q;
    if (state_d == ST_IDLE || state_d != state_q) begin
      cnt_d = '0;
    end else if (!dwell_done) begin
      cnt_d = cnt_q + CW'(1);
    end
    // Entering or switching a grant; sel is left alone on entry to idle.
    if (state_d != state_q) begin
      if (state_d == ST_OWN_A) begin
        last_b_d = 1'b0;
        sel_d    = 1'b0;
      end else if (state_d == ST_OWN_B) begin
        last_b_d = 1'b1;
        sel_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      last_b_q <= 1'b1;
      sel_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_b_q <= last_b_d;
      sel_q    <= sel_d;
    end
  end

  // Data uses the select in force during the current cycle, so a switch shows
  // up on o one edge after it appears on sel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q       <= '0;
      o_valid_q <= 1'b0;
    end else begin
      if (state_q != ST_IDLE) begin
        o_q <= sel_q ? data_b : data_a;
      end
      o_valid_q <= (state_q != ST_IDLE);
    end
  end

  assign gnt_a   = (state_q == ST_OWN_A);
  assign gnt_b   = (state_q == ST_OWN_B);
  assign sel     = sel_q;
  assign o       = o_q;
  assign o_valid = o_valid_q;

endmodule

// File: doc/mux64_arbiter.md
# mux64_arbiter

Two-requester arbiter and sequencer for the 64-bit 2:1 datapath multiplexer (MUX2T1_64) that feeds the framework's display/data path. It grants the shared mux to one of two sources with round-robin fairness and a minimum dwell time. It drives the mux `sel` line and presents a registered, valid-qualified 64-bit result to downstream logic.

## Interface
- `W`, 64: data width of each source and of the output.
- `DWELL`, 4: minimum granted cycles before a contending requester may take over; legal range 1..255.
- `CW`, 8: dwell counter width; must satisfy 2^CW > DWELL.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_a`  in  1  source A requests the mux; level, held while it wants the mux.
- `req_b`  in  1  source B requests the mux.
- `data_a`  in  W  source A data (mux input `a`).
- `data_b`  in  W  source B data (mux input `b`).
- `gnt_a`  out  1  source A currently owns the mux; registered.
- `gnt_b`  out  1  source B currently owns the mux; registered.
- `sel`  out  1  mux select; 0 = `data_a`, 1 = `data_b`; registered.
- `o`  out  W  registered mux output.
- `o_valid`  out  1  `o` was loaded on the last edge from a granted source.

## Operation
- States: IDLE, OWN_A, OWN_B. `gnt_a` = (state==OWN_A); `gnt_b` = (state==OWN_B); never both high.
- `last` register records the most recently granted source; reset value B, so A wins the first tie.
- IDLE: `req_a` only -> OWN_A; `req_b` only -> OWN_B; both -> the source that is not `last`; neither -> stay.
- OWN_x, own request high:
  - the other request is low -> stay;
  - the other request is high and `cnt` == DWELL-1 -> switch directly to OWN_other (no IDLE gap);
  - otherwise stay.
- OWN_x, own request low: other request high -> switch to OWN_other immediately, regardless of `cnt`; otherwise -> IDLE.
- `cnt` clears to 0 on every edge that enters or switches a grant. It increments by 1 on each edge that stays in OWN_x and saturates at DWELL-1. With DWELL=1, two contending requesters alternate every cycle.
- `last` updates on every edge that enters OWN_A/OWN_B.
- `sel` follows the next state: 0 for OWN_A, 1 for OWN_B, and holds its prior value on entry to IDLE.
- Datapath:
  - On each edge where the current state is OWN_x: `o` <= (`sel` ? `data_b` : `data_a`) using the current `sel`, and `o_valid` <= 1.
  - In IDLE: `o` holds and `o_valid` <= 0.
- Reset (asserted at any time, including mid-grant): state IDLE, `gnt_a`=`gnt_b`=0, `sel`=0, `o`=0, `o_valid`=0, `cnt`=0, `last`=B. Outputs clear immediately; resume on the first edge after release.

## Timing
- Request to grant: 1 edge. A request seen at edge E gives `gnt`/`sel` valid after E.
- Grant to data: 1 further edge. `o`/`o_valid` reflect the granted source after E+1, so request-to-valid latency is 2 cycles.
- Switch at edge S: `gnt`/`sel` change after S. `o` loaded at S still carries the old source; new-source data appears after S+1.
- Release to idle: `o_valid` falls one edge after the grant drops; `o` retains its last value.
- Inputs `data_a`/`data_b` are sampled only at edges; no combinational path from inputs to outputs.

## Test plan
1. Reset mid-grant: `rst_n` low while OWN_B with `o`=0xFFFF_FFFF_FFFF_FFFF -> `gnt_b`, `sel`, `o`, `o_valid` all 0 before the next edge. After release, a single `req_b` is granted after 1 edge.
2. Single request: `data_a`=1, `data_b`=0, `req_a`=1 from IDLE -> `gnt_a`=1, `sel`=0 after edge 1; `o`=1, `o_valid`=1 after edge 2.
3. Contention, DWELL=4: both requests high from reset, `data_a`=0xA, `data_b`=0xB -> A granted first. `gnt` alternates A,B every 4 cycles; `o` follows one cycle behind each `sel` change.
4. Early release: OWN_A for 2 cycles, `req_a` drops while `req_b` high -> OWN_B and `sel`=1 after the next edge, with no wait for dwell.
5. Both drop: OWN_B, both requests fall -> IDLE after 1 edge. `o_valid` goes to 0 one edge later and `o` holds 0xB.
6. Round-robin tie: B served last, IDLE, then both requests rise on the same cycle -> `gnt_a` wins. Repeat after A was last -> `gnt_b` wins.
